imem_dmem_arbiter: RTL and testbench

- Shares one single-port, fixed-latency SRAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Arbitrates between them, sequences each multi-cycle access and returns read data with a one-cycle ready pulse.
- The pipeline derives its freeze from the ready pulses: IF stalls while its request is pending and not ready; the same holds for MEM.
- Data side has priority; a streak limit prevents fetch starvation.

---
 rtl/imem_dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch and data access.
// Data wins ties unless it has already won MAX_D_STREAK times while a fetch waited.
module imem_dmem_arbiter #(
   parameter int LATENCY      = 4,
   parameter int MAX_D_STREAK = 2,
   parameter int CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        mem_rd_en,
   input  logic        mem_wr_en,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        sram_en,
   output logic        sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic {GNT_IF, GNT_D} gnt_t;

   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] MAX_STREAK = CNT_W'(MAX_D_STREAK);

   state_t            state_reg, state_next;
   gnt_t              gnt_reg, gnt_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [CNT_W-1:0]  d_streak_reg, d_streak_next;
   logic              drop_reg, drop_next;
   logic              we_reg, we_next;
   logic [31:0]       addr_reg, addr_next;
   logic [31:0]       wdata_reg, wdata_next;
   logic [31:0]       if_rdata_reg, if_rdata_next;
   logic [31:0]       mem_rdata_reg, mem_rdata_next;
   logic              d_req;
   logic              drop_now;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         gnt_reg       <= GNT_IF;
         cnt_reg       <= '0;
         d_streak_reg  <= '0;
         drop_reg      <= 1'b0;
         we_reg        <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         if_rdata_reg  <= '0;
         mem_rdata_reg <= '0;
      end else begin
         state_reg     <= state_next;
         gnt_reg       <= gnt_next;
         cnt_reg       <= cnt_next;
         d_streak_reg  <= d_streak_next;
         drop_reg      <= drop_next;
         we_reg        <= we_next;
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         if_rdata_reg  <= if_rdata_next;
         mem_rdata_reg <= mem_rdata_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      gnt_next       = gnt_reg;
      cnt_next       = cnt_reg;
      d_streak_next  = d_streak_reg;
      drop_next      = drop_reg;
      we_next        = we_reg;
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      if_rdata_next  = if_rdata_reg;
      mem_rdata_next = mem_rdata_reg;
      d_req          = mem_rd_en | mem_wr_en;
      // A flush in the final access cycle must also suppress the capture.
      drop_now       = drop_reg | (gnt_reg == GNT_IF && if_flush);

      case (state_reg)
         IDLE: begin
            if (d_req && (!if_req || d_streak_reg < MAX_STREAK)) begin
               gnt_next      = GNT_D;
               d_streak_next = if_req ? d_streak_reg + 1'b1 : '0;
               addr_next     = mem_addr;
               wdata_next    = mem_wdata;
               we_next       = mem_wr_en;
               cnt_next      = '0;
               drop_next     = 1'b0;
               state_next    = ACCESS;
            end else if (if_req) begin
               gnt_next      = GNT_IF;
               d_streak_next = '0;
               addr_next     = if_addr;
               wdata_next    = '0;
               we_next       = 1'b0;
               cnt_next      = '0;
               drop_next     = 1'b0;
               state_next    = ACCESS;
            end
         end
         ACCESS: begin
            cnt_next  = cnt_reg + 1'b1;
            drop_next = drop_now;
            if (cnt_reg == LAST_CNT) begin
               state_next = RESP;
               if (gnt_reg == GNT_IF && !drop_now)
                  if_rdata_next = sram_rdata;
               if (gnt_reg == GNT_D && !we_reg)
                  mem_rdata_next = sram_rdata;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign sram_en    = (state_reg == ACCESS);
   assign sram_we    = (state_reg == ACCESS) & we_reg;
   assign sram_addr  = addr_reg;
   assign sram_wdata = wdata_reg;
   assign if_rdata   = if_rdata_reg;
   assign mem_rdata  = mem_rdata_reg;
   assign if_ready   = (state_reg == RESP) & (gnt_reg == GNT_IF) & !drop_reg;
   assign mem_ready  = (state_reg == RESP) & (gnt_reg == GNT_D);

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: stimulus queues expected responses,
// a negedge monitor matches every ready pulse against the queue.
module tb_imem_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_flush, mem_rd_en, mem_wr_en;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
   logic        if_ready, mem_ready, sram_en, sram_we;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   acc_cnt  = 0;

   imem_dmem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: data is only correct in the 4th access cycle, garbage before.
   always @(posedge clk or negedge rst) begin
      if (!rst)         acc_cnt <= 0;
      else if (sram_en) acc_cnt <= acc_cnt + 1;
      else              acc_cnt <= 0;
   end

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h10:  return 32'hE3A01005;
         32'h14:  return 32'hE3A02007;
         32'h200: return 32'h12345678;
         32'h204: return 32'hCAFEF00D;
         default: return a ^ 32'hA5A50000;
      endcase
   endfunction

   always_comb begin
      sram_rdata = 32'hBAD00000 | 32'(acc_cnt);
      if (acc_cnt == 3) sram_rdata = rom(sram_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst && (if_ready || mem_ready)) begin
         check("ready_exclusive", {31'd0, if_ready & mem_ready}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_ready", {30'd0, if_ready, mem_ready}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("ready_side", {31'd0, mem_ready}, {31'd0, e.is_d});
            check("ready_cycle", 32'(cyc), 32'(e.due));
            if (e.is_d) check("mem_rdata", mem_rdata, e.data);
            else        check("if_rdata", if_rdata, e.data);
            $display("resp %s data=%h cycle=%0d", e.is_d ? "D " : "IF", e.is_d ? mem_rdata : if_rdata, cyc);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit is_d, input logic [31:0] data, input int due);
      exp_t e;
      e.is_d = is_d;
      e.data = data;
      e.due  = due;
      sb.push_back(e);
   endtask

   // Called in the grant (IDLE) cycle; walks the 4 ACCESS cycles and RESP.
   task automatic access_seq(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input bit clr_if, input bit clr_d, input int flush_at);
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         if (k == 1 && clr_if) if_req = 1'b0;
         if (k == 1 && clr_d) begin
            mem_rd_en = 1'b0;
            mem_wr_en = 1'b0;
         end
         if_flush = (k == flush_at);
         check("sram_en_access", {31'd0, sram_en}, 32'd1);
         check("sram_we_access", {31'd0, sram_we}, {31'd0, we});
         check("sram_addr", sram_addr, addr);
         if (we) check("sram_wdata", sram_wdata, wdata);
      end
      next_cycle();
      if_flush = 1'b0;
      check("sram_en_resp", {31'd0, sram_en}, 32'd0);
      check("sram_we_resp", {31'd0, sram_we}, 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sram_en"},   {31'd0, sram_en},   32'd0);
      check({tag, "_sram_we"},   {31'd0, sram_we},   32'd0);
      check({tag, "_sram_addr"}, sram_addr,          32'd0);
      check({tag, "_sram_wdata"}, sram_wdata,        32'd0);
      check({tag, "_if_ready"},  {31'd0, if_ready},  32'd0);
      check({tag, "_mem_ready"}, {31'd0, mem_ready}, 32'd0);
      check({tag, "_if_rdata"},  if_rdata,           32'd0);
      check({tag, "_mem_rdata"}, mem_rdata,          32'd0);
   endtask

   int t0;

   initial begin
      rst = 1'b0;
      if_req = 0; if_flush = 0; mem_rd_en = 0; mem_wr_en = 0;
      if_addr = '0; mem_addr = '0; mem_wdata = '0;
      #2;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      next_cycle();

      // 1: fetch only
      t0 = cyc; if_req = 1; if_addr = 32'h10;
      push(0, 32'hE3A01005, t0 + 5);
      access_seq(0, 32'h10, 0, 1, 0, 0);
      next_cycle();
      check("idle_after_fetch", {31'd0, sram_en}, 32'd0);

      // 2: simultaneous fetch and load, data first
      t0 = cyc; if_req = 1; if_addr = 32'h14; mem_rd_en = 1; mem_addr = 32'h200;
      push(1, 32'h12345678, t0 + 5);
      push(0, 32'hE3A02007, t0 + 11);
      access_seq(0, 32'h200, 0, 0, 1, 0);
      next_cycle();
      check("idle_between", {31'd0, sram_en}, 32'd0);
      access_seq(0, 32'h14, 0, 1, 0, 0);
      next_cycle();

      // 3: both held, grant order D D IF D D IF
      t0 = cyc; if_req = 1; if_addr = 32'h10; mem_rd_en = 1; mem_addr = 32'h204;
      push(1, 32'hCAFEF00D, t0 + 5);
      push(1, 32'hCAFEF00D, t0 + 11);
      push(0, 32'hE3A01005, t0 + 17);
      push(1, 32'hCAFEF00D, t0 + 23);
      push(1, 32'hCAFEF00D, t0 + 29);
      push(0, 32'hE3A01005, t0 + 35);
      for (int g = 0; g < 6; g++) begin
         if (g != 0) next_cycle();
         access_seq(0, (g % 3 == 2) ? 32'h10 : 32'h204, 0, 0, 0, 0);
      end
      if_req = 0; mem_rd_en = 0;
      next_cycle();

      // 4: flush in the second access cycle, then a normal fetch
      if_req = 1; if_addr = 32'h14;
      access_seq(0, 32'h14, 0, 1, 0, 2);
      check("flush_no_ready", {31'd0, if_ready}, 32'd0);
      check("flush_if_rdata", if_rdata, 32'hE3A01005);
      next_cycle();
      t0 = cyc; if_req = 1; if_addr = 32'h14;
      push(0, 32'hE3A02007, t0 + 5);
      access_seq(0, 32'h14, 0, 1, 0, 0);
      next_cycle();

      // 5: store, then read+write conflict handled as store
      t0 = cyc; mem_wr_en = 1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF;
      push(1, 32'hCAFEF00D, t0 + 5);
      access_seq(1, 32'h100, 32'hDEADBEEF, 0, 1, 0);
      next_cycle();
      t0 = cyc; mem_wr_en = 1; mem_rd_en = 1; mem_addr = 32'h104; mem_wdata = 32'h0BADCAFE;
      push(1, 32'hCAFEF00D, t0 + 5);
      access_seq(1, 32'h104, 32'h0BADCAFE, 0, 1, 0);
      next_cycle();

      // 6: reset in the middle of a fetch
      if_req = 1; if_addr = 32'h10;
      next_cycle();
      if_req = 0;
      next_cycle();
      check("pre_reset_sram_en", {31'd0, sram_en}, 32'd1);
      #2 rst = 1'b0;
      #1 check_all_zero("midreset");
      next_cycle();
      rst = 1'b1;
      repeat (8) next_cycle();
      check("post_reset_if_rdata", if_rdata, 32'd0);
      t0 = cyc; if_req = 1; if_addr = 32'h10;
      push(0, 32'hE3A01005, t0 + 5);
      access_seq(0, 32'h10, 0, 1, 0, 0);
      repeat (3) next_cycle();

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
